// File: rtl/addr_latch_inc.sv
// addr_latch_inc: 16-bit address latch (AL) with a +/-1 incrementer.
//
// AL captures a register value placed on the address-side buses by the
// register file. It drives that value to the address pins. It also returns
// AL, AL+1 or AL-1 on the same buses so the register file can write it back.
//
// Optional feature: define ADDR_IS_1_DETECT_EN to enable the AL == 1 detector.
// When the macro is undefined, address_is_1 is tied low.
//
// Ports:
//   clk            system clock; all state changes on the rising edge
//   nreset         synchronous active-low reset (AL <= 0)
//   db_lo_as       inout, address-side low data bus (shared with the register file)
//   db_hi_as       inout, address-side high data bus (shared with the register file)
//   ctl_al_we      load {db_hi_as, db_lo_as} into AL
//   ctl_inc_cy     incrementer active (+/-1); 0 = pass-through
//   ctl_inc_dec    1 = decrement, 0 = increment
//   ctl_inc_limit7 only AL[RMASK_BITS-1:0] counts; the upper bits are held
//   ctl_al_self    load the incrementer result into AL
//   ctl_al_oe      drive the incrementer result onto db_hi_as/db_lo_as
//   ctl_ab_oe      drive AL onto abus
//   abus           address pins; Z when ctl_ab_oe = 0
//   address_is_1   AL == 1 (0 when the detector is disabled)
module addr_latch_inc #(
    parameter int unsigned AW         = 16,
    parameter int unsigned RMASK_BITS = 7
) (
    input  logic              clk,
    input  logic              nreset,
    inout  wire  [AW/2-1:0]   db_lo_as,
    inout  wire  [AW/2-1:0]   db_hi_as,
    input  logic              ctl_al_we,
    input  logic              ctl_inc_cy,
    input  logic              ctl_inc_dec,
    input  logic              ctl_inc_limit7,
    input  logic              ctl_al_self,
    input  logic              ctl_al_oe,
    input  logic              ctl_ab_oe,
    output logic [AW-1:0]     abus,
    output logic              address_is_1
);

    localparam int unsigned HW = AW / 2;

    logic [AW-1:0] al;
    logic [AW-1:0] step_c;
    logic [AW-1:0] inc_c;
    logic          bus_oe_c;

    // Incrementer. In limited mode only the low bits take the +/-1 result.
    // The low bits of the full-width sum equal the low-field sum mod 2^RMASK_BITS.
    always_comb begin
        step_c = ctl_inc_dec ? (al - AW'(1)) : (al + AW'(1));
        inc_c  = al;
        if (ctl_inc_cy) begin
            if (ctl_inc_limit7)
                inc_c = {al[AW-1:RMASK_BITS], step_c[RMASK_BITS-1:0]};
            else
                inc_c = step_c;
        end
    end

    // Address latch: reset, then bus load, then self-update, else hold.
    always_ff @(posedge clk) begin
        if (!nreset)
            al <= '0;
        else if (ctl_al_we)
            al <= {db_hi_as, db_lo_as};
        else if (ctl_al_self)
            al <= inc_c;
    end

    // Write-back drive. It is released while AL loads, so the block never
    // fights the register file for the bus in that cycle.
    assign bus_oe_c = ctl_al_oe & ~ctl_al_we;
    assign db_hi_as = bus_oe_c ? inc_c[AW-1:HW] : {HW{1'bz}};
    assign db_lo_as = bus_oe_c ? inc_c[HW-1:0]  : {HW{1'bz}};

    assign abus = ctl_ab_oe ? al : {AW{1'bz}};

`ifdef ADDR_IS_1_DETECT_EN
    // Used by block instructions to see BC reach 1 before the final decrement.
    assign address_is_1 = (al == AW'(1));
`else
    assign address_is_1 = 1'b0;
`endif

endmodule
